// File: rtl/avmm_channel_arbiter_if.sv
// Bus bundle between NUM_REQ AVMM requesters, the channel arbiter and one memory channel.
// The arbiter modport is the block itself; master is a requester, slave is the memory channel.
interface avmm_channel_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 512
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [NUM_REQ-1:0]                 s_read;
    logic [NUM_REQ-1:0]                 s_write;
    logic [NUM_REQ-1:0][51:6]           s_address;
    logic [NUM_REQ-1:0][BE_WIDTH-1:0]   s_byteenable;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] s_writedata;
    logic [NUM_REQ-1:0]                 s_waitrequest;
    logic [DATA_WIDTH-1:0]              s_readdata;
    logic [NUM_REQ-1:0]                 s_readdatavalid;

    logic                               m_read;
    logic                               m_write;
    logic [51:6]                        m_address;
    logic [BE_WIDTH-1:0]                m_byteenable;
    logic [DATA_WIDTH-1:0]              m_writedata;
    logic                               m_ready;
    logic [DATA_WIDTH-1:0]              m_readdata;
    logic                               m_readdatavalid;

    modport arbiter (
        input  s_read, s_write, s_address, s_byteenable, s_writedata,
        output s_waitrequest, s_readdata, s_readdatavalid,
        output m_read, m_write, m_address, m_byteenable, m_writedata,
        input  m_ready, m_readdata, m_readdatavalid
    );

    modport master (
        output s_read, s_write, s_address, s_byteenable, s_writedata,
        input  s_waitrequest, s_readdata, s_readdatavalid
    );

    modport slave (
        input  m_read, m_write, m_address, m_byteenable, m_writedata,
        output m_ready, m_readdata, m_readdatavalid
    );
endinterface

// File: rtl/avmm_channel_arbiter.sv
// Round-robin arbiter sharing one in-order AVMM memory channel among NUM_REQ requesters.
// Commands issue combinationally; read responses are steered back through an in-order tag FIFO.
module avmm_channel_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int MAX_RD_OUT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    avmm_channel_arbiter_if.arbiter       bus,
    output logic [$clog2(MAX_RD_OUT):0]   rd_outstanding,
    output logic                          err_unexp_rsp
);
    localparam int REQ_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_RD_OUT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [REQ_W:0]   NUM_REQ_L  = (REQ_W + 1)'(NUM_REQ);
    localparam logic [REQ_W-1:0] LAST_REQ_L = REQ_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] MAX_CNT_L  = CNT_W'(MAX_RD_OUT);

    logic [REQ_W-1:0] rr_ptr_r;
    logic [REQ_W-1:0] tag_mem_r [MAX_RD_OUT];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             err_r;

    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             pop_s;
    logic             push_s;
    logic             can_push_s;
    logic             issue_s;
    logic             grant_found_s;
    logic             grant_is_read_s;
    logic [REQ_W-1:0] grant_idx_s;
    logic [REQ_W-1:0] head_tag_s;

    assign fifo_empty_s   = (count_r == CNT_W'(0));
    assign fifo_full_s    = (count_r == MAX_CNT_L);
    assign pop_s          = !rst && bus.m_readdatavalid && !fifo_empty_s;
    // A slot freed by this cycle's response may be reused by this cycle's read.
    assign can_push_s     = !fifo_full_s || pop_s;
    assign issue_s        = !rst && bus.m_ready && grant_found_s;
    assign push_s         = issue_s && grant_is_read_s;
    assign head_tag_s     = tag_mem_r[rd_ptr_r];
    assign rd_outstanding = count_r;
    assign err_unexp_rsp  = err_r;

    // Round-robin search from rr_ptr; reads need a free tag, writes never do.
    always_comb begin : arb_search
        logic [REQ_W:0]   cand_sum_v;
        logic [REQ_W-1:0] cand_v;
        cand_sum_v      = {(REQ_W + 1){1'b0}};
        cand_v          = {REQ_W{1'b0}};
        grant_found_s   = 1'b0;
        grant_is_read_s = 1'b0;
        grant_idx_s     = {REQ_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum_v = {1'b0, rr_ptr_r} + (REQ_W + 1)'(k);
            if (cand_sum_v >= NUM_REQ_L) begin
                cand_sum_v = cand_sum_v - NUM_REQ_L;
            end else begin
                cand_sum_v = cand_sum_v;
            end
            cand_v = cand_sum_v[REQ_W-1:0];
            if (grant_found_s) begin
                grant_found_s = 1'b1;
            end else if (bus.s_read[cand_v] && can_push_s) begin
                grant_found_s   = 1'b1;
                grant_is_read_s = 1'b1;
                grant_idx_s     = cand_v;
            end else if (bus.s_write[cand_v]) begin
                grant_found_s   = 1'b1;
                grant_is_read_s = 1'b0;
                grant_idx_s     = cand_v;
            end else begin
                grant_found_s = 1'b0;
            end
        end
    end

    // Downstream command and upstream waitrequest for the winning requester.
    always_comb begin
        bus.s_waitrequest = {NUM_REQ{1'b1}};
        bus.m_read        = 1'b0;
        bus.m_write       = 1'b0;
        bus.m_address     = 46'd0;
        bus.m_byteenable  = {(DATA_WIDTH / 8){1'b0}};
        bus.m_writedata   = {DATA_WIDTH{1'b0}};
        if (issue_s) begin
            bus.s_waitrequest[grant_idx_s] = 1'b0;
            bus.m_read    = grant_is_read_s;
            bus.m_write   = !grant_is_read_s;
            bus.m_address = bus.s_address[grant_idx_s];
            if (!grant_is_read_s) begin
                bus.m_byteenable = bus.s_byteenable[grant_idx_s];
                bus.m_writedata  = bus.s_writedata[grant_idx_s];
            end else begin
                bus.m_byteenable = {(DATA_WIDTH / 8){1'b0}};
            end
        end else begin
            bus.m_read = 1'b0;
        end
    end

    // Response steering: the oldest tag owns the returning beat.
    always_comb begin
        bus.s_readdata      = bus.m_readdata;
        bus.s_readdatavalid = {NUM_REQ{1'b0}};
        if (pop_s) begin
            bus.s_readdatavalid[head_tag_s] = 1'b1;
        end else begin
            bus.s_readdatavalid = {NUM_REQ{1'b0}};
        end
    end

    // Round-robin pointer advances past the granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= {REQ_W{1'b0}};
        end else if (issue_s) begin
            rr_ptr_r <= (grant_idx_s == LAST_REQ_L) ? {REQ_W{1'b0}} : grant_idx_s + REQ_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Tag storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            tag_mem_r[wr_ptr_r] <= grant_idx_s;
        end
    end

    // Tag FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flag for a response with no matching tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (bus.m_readdatavalid && fifo_empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
endmodule

// File: tb/tb_avmm_channel_arbiter.sv
// Randomized scoreboard bench for avmm_channel_arbiter against a queue-based reference model.
module tb_avmm_channel_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 512;
    localparam int MAX = 64;

    typedef struct { int cyc; bit is_read; int idx; logic [45:0] addr; logic [63:0] be; logic [511:0] wd; } cmd_t;
    typedef struct { int cyc; int tag; logic [511:0] data; } rsp_t;
    typedef struct { int cyc; logic [3:0] wreq; int outst; bit err; } stat_t;

    logic       clk;
    logic       rst;
    logic [6:0] rd_outstanding;
    logic       err_unexp_rsp;

    avmm_channel_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();

    avmm_channel_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_RD_OUT(MAX)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rd_outstanding(rd_outstanding), .err_unexp_rsp(err_unexp_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cmd_t  cmd_q[$];
    rsp_t  rsp_q[$];
    stat_t stat_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    // Reference model state
    int    m_rr = 0;
    int    m_tags[$];
    bit    m_err = 1'b0;

    // Stimulus knobs
    logic [3:0] rd_v = 4'd0;
    logic [3:0] wr_v = 4'd0;
    bit         rdy_v = 1'b0;
    bit         rv_v = 1'b0;
    bit         rst_v = 1'b1;
    bit         fix_addr = 1'b0;

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and predict the DUT's response from the model.
    task automatic step();
        stat_t st;
        cmd_t  c;
        rsp_t  r;
        int    win;
        bit    win_rd;
        bit    pop;
        bit    canpush;
        logic [63:0] t;
        @(negedge clk);
        cyc++;
        rst                 = rst_v;
        bus.s_read          = rd_v;
        bus.s_write         = wr_v;
        bus.m_ready         = rdy_v;
        bus.m_readdatavalid = rv_v;
        bus.m_readdata      = rand512();
        for (int i = 0; i < NR; i++) begin
            t = {$urandom(), $urandom()};
            bus.s_address[i]    = t[45:0];
            bus.s_byteenable[i] = {$urandom(), $urandom()};
            bus.s_writedata[i]  = rand512();
        end
        if (fix_addr) bus.s_address[2] = 46'h10;

        st.cyc = cyc; st.wreq = 4'b1111; st.outst = m_tags.size(); st.err = m_err;
        if (rst_v) begin
            m_tags.delete();
            m_rr  = 0;
            m_err = 1'b0;
        end else begin
            pop     = rv_v && (m_tags.size() > 0);
            canpush = (m_tags.size() < MAX) || pop;
            win = -1; win_rd = 1'b0;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_rr + k) % NR;
                if (win < 0 && rd_v[i] && canpush) begin win = i; win_rd = 1'b1; end
                else if (win < 0 && wr_v[i]) begin win = i; win_rd = 1'b0; end
            end
            if (pop) begin
                r.cyc = cyc; r.tag = m_tags[0]; r.data = bus.m_readdata;
                rsp_q.push_back(r);
            end
            if (rdy_v && win >= 0) begin
                st.wreq[win] = 1'b0;
                c.cyc = cyc; c.is_read = win_rd; c.idx = win;
                c.addr = bus.s_address[win]; c.be = bus.s_byteenable[win]; c.wd = bus.s_writedata[win];
                cmd_q.push_back(c);
            end
            if (rv_v && m_tags.size() == 0) m_err = 1'b1;
            if (pop) void'(m_tags.pop_front());
            if (rdy_v && win >= 0) begin
                if (win_rd) m_tags.push_back(win);
                m_rr = (win + 1) % NR;
            end
        end
        stat_q.push_back(st);
    endtask

    stat_t ms;
    cmd_t  mc;
    rsp_t  mr;

    // Monitor: compares what the DUT presents each cycle against the queued predictions.
    always @(negedge clk) begin
        #2;
        if (stat_q.size() > 0) begin
            ms = stat_q.pop_front();
            chk("waitrequest", bus.s_waitrequest, ms.wreq);
            chk("rd_outstanding", rd_outstanding, ms.outst);
            chk("err_unexp_rsp", err_unexp_rsp, ms.err);
            if (bus.m_read || bus.m_write) begin
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd (cycle %0d): got m_read=%0b m_write=%0b, expected none", ms.cyc, bus.m_read, bus.m_write);
                end else begin
                    mc = cmd_q.pop_front();
                    chk("cmd_cycle", ms.cyc, mc.cyc);
                    chk("m_read", bus.m_read, mc.is_read);
                    chk("m_write", bus.m_write, !mc.is_read);
                    chk("m_address", bus.m_address, mc.addr);
                    if (!mc.is_read) begin
                        chk("m_byteenable", bus.m_byteenable, mc.be);
                        chk("m_writedata", bus.m_writedata, mc.wd);
                    end
                end
            end else begin
                chk("idle_m_address", bus.m_address, 46'd0);
                if (cmd_q.size() > 0 && cmd_q[0].cyc <= ms.cyc) begin
                    checks++; errors++;
                    $display("FAIL missing_cmd (cycle %0d): got no strobe, expected command from %0d", ms.cyc, cmd_q[0].idx);
                    void'(cmd_q.pop_front());
                end
            end
            if (|bus.s_readdatavalid) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp (cycle %0d): got s_readdatavalid=%b, expected 0000", ms.cyc, bus.s_readdatavalid);
                end else begin
                    mr = rsp_q.pop_front();
                    chk("rsp_cycle", ms.cyc, mr.cyc);
                    chk("s_readdatavalid", bus.s_readdatavalid, 4'b0001 << mr.tag);
                    chk("s_readdata", bus.s_readdata, mr.data);
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= ms.cyc) begin
                checks++; errors++;
                $display("FAIL missing_rsp (cycle %0d): got s_readdatavalid=0000, expected tag %0d", ms.cyc, rsp_q[0].tag);
                void'(rsp_q.pop_front());
            end
        end
    end

    task automatic drain();
        rd_v = 4'd0; wr_v = 4'd0; rv_v = 1'b1;
        for (int n = 0; n < 200 && m_tags.size() > 0; n++) step();
        rv_v = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus.s_read = '0; bus.s_write = '0; bus.s_address = '0; bus.s_byteenable = '0;
        bus.s_writedata = '0; bus.m_ready = 1'b0; bus.m_readdata = '0; bus.m_readdatavalid = 1'b0;

        // Reset, with requests present to show everything is held off
        rst_v = 1'b1; rd_v = 4'hF; rdy_v = 1'b1; step(); step();
        rst_v = 1'b0; rd_v = 4'd0; step();

        // Single read from requester 2 at line 0x10
        rd_v = 4'b0100; fix_addr = 1'b1; step();
        rd_v = 4'd0; fix_addr = 1'b0; repeat (3) step();
        rv_v = 1'b1; step(); rv_v = 1'b0; step();

        // Fairness from a freshly reset pointer
        rst_v = 1'b1; step(); rst_v = 1'b0;
        rd_v = 4'hF; repeat (16) step();
        drain();

        // Ready gating with two pending readers
        rd_v = 4'b0011;
        for (int n = 0; n < 8; n++) begin rdy_v = (n % 2 == 0); step(); end
        rdy_v = 1'b1; drain();

        // Tag budget exhaustion
        rd_v = 4'b0001;
        for (int n = 0; n < 200 && m_tags.size() < MAX; n++) step();
        rd_v = 4'b1101; wr_v = 4'b0010; step();
        wr_v = 4'd0; step();
        rd_v = 4'b0001; rv_v = 1'b1; step();
        drain();

        // Response ordering 3,1,3,0
        rd_v = 4'b1000; step(); rd_v = 4'b0010; step();
        rd_v = 4'b1000; step(); rd_v = 4'b0001; step();
        drain();

        // Unexpected response, then reset with five reads in flight
        rv_v = 1'b1; step(); rv_v = 1'b0; step();
        rd_v = 4'b0100; repeat (5) step();
        rd_v = 4'd0; rst_v = 1'b1; step(); rst_v = 1'b0;
        rd_v = 4'hF; step(); rd_v = 4'd0;
        rv_v = 1'b1; repeat (3) step(); rv_v = 1'b0; step();
        rst_v = 1'b1; step(); rst_v = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rd_v  = 4'($urandom());
            wr_v  = 4'($urandom()) & 4'($urandom());
            rdy_v = ($urandom_range(0, 9) < 7);
            rv_v  = (m_tags.size() > 0) ? ($urandom_range(0, 9) < ((m_tags.size() > 40) ? 8 : 3))
                                        : ($urandom_range(0, 99) == 0);
            rst_v = ($urandom_range(0, 499) == 0);
            step();
        end
        rst_v = 1'b0; rdy_v = 1'b1;
        drain();
        step();

        @(negedge clk); #4;
        chk("cmd_queue_drained", cmd_q.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
